// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: fetch/decode enables, bubble injection on jumps, load-use and memory stalls.
// Outputs are combinational from state and inputs (zero latency); a pending memory access holds both latches until mem_ready.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [5:0]  sel_a_dec,
    input  logic [4:0]  sel_b_dec,
    input  logic        uses_b_dec,
    input  logic [5:0]  sel_out_ex,
    input  logic        ex_is_load,
    input  logic        jmp_taken,
    input  logic        lam_new,
    input  logic        mem_ready,
    output logic        fetch_en,
    output logic        dec_en,
    output logic        dec_flush,
    output logic        pc_load,
    output logic        mem_err,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [9:0] TCNT_LAST = 10'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [1:0] fcnt, fcnt_nxt;
    logic [9:0] tcnt, tcnt_nxt;
    logic       err_set;
    logic       hazard;

    // Source B is only 5 bits wide, so it can never name the upper half of the register file.
    assign hazard = dec_valid && ex_is_load && (sel_out_ex != 6'd0) &&
                    ((sel_a_dec == sel_out_ex) ||
                     (uses_b_dec && ({1'b0, sel_b_dec} == sel_out_ex)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            fcnt         <= 2'd0;
            tcnt         <= 10'd0;
            mem_err      <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            state   <= state_nxt;
            fcnt    <= fcnt_nxt;
            tcnt    <= tcnt_nxt;
            mem_err <= mem_err | err_set;
            if (!fetch_en && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        tcnt_nxt  = tcnt;
        err_set   = 1'b0;
        case (state)
            ST_RUN: begin
                if (jmp_taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = ST_FLUSH;
                        fcnt_nxt  = FCNT_INIT;
                    end
                end else if (lam_new && !mem_ready) begin
                    state_nxt = ST_MEM_WAIT;
                    tcnt_nxt  = 10'd1;
                end
            end
            ST_FLUSH: begin
                if (jmp_taken) begin
                    fcnt_nxt = FCNT_INIT;
                end else if (fcnt <= 2'd1) begin
                    state_nxt = ST_RUN;
                    fcnt_nxt  = 2'd0;
                end else begin
                    fcnt_nxt = fcnt - 2'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = ST_RUN;
                    tcnt_nxt  = 10'd0;
                end else begin
                    tcnt_nxt = tcnt + 10'd1;
                    // tcnt lags the cycle count by one because the lam_new cycle is spent in RUN.
                    if ((tcnt + 10'd1) == TCNT_LAST) begin
                        state_nxt = ST_ERROR;
                        err_set   = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_comb begin
        fetch_en  = 1'b1;
        dec_en    = 1'b1;
        dec_flush = 1'b0;
        pc_load   = 1'b0;
        if (reset) begin
            fetch_en  = 1'b0;
            dec_en    = 1'b0;
            dec_flush = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (jmp_taken) begin
                        pc_load   = 1'b1;
                        dec_flush = 1'b1;
                    end else if (lam_new) begin
                        if (!mem_ready) begin
                            fetch_en = 1'b0;
                            dec_en   = 1'b0;
                        end
                    end else if (hazard) begin
                        fetch_en  = 1'b0;
                        dec_flush = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    dec_flush = 1'b1;
                    pc_load   = jmp_taken;
                end
                ST_MEM_WAIT: begin
                    fetch_en = mem_ready;
                    dec_en   = mem_ready;
                end
                default: begin
                    fetch_en = 1'b0;
                    dec_en   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with FLUSH_CYCLES=2 and MEM_TIMEOUT=4.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [5:0]  sel_a_dec;
    logic [4:0]  sel_b_dec;
    logic        uses_b_dec;
    logic [5:0]  sel_out_ex;
    logic        ex_is_load;
    logic        jmp_taken;
    logic        lam_new;
    logic        mem_ready;
    logic        fetch_en;
    logic        dec_en;
    logic        dec_flush;
    logic        pc_load;
    logic        mem_err;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .sel_a_dec(sel_a_dec),
        .sel_b_dec(sel_b_dec), .uses_b_dec(uses_b_dec), .sel_out_ex(sel_out_ex),
        .ex_is_load(ex_is_load), .jmp_taken(jmp_taken), .lam_new(lam_new),
        .mem_ready(mem_ready), .fetch_en(fetch_en), .dec_en(dec_en),
        .dec_flush(dec_flush), .pc_load(pc_load), .mem_err(mem_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Advance one edge and land just after it, ready to drive the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #2;
        total++; if (fetch_en !== 1'b0)  begin bad++; $display("FAIL rst_fetch_en got=%b want=0", fetch_en); end
        total++; if (dec_en !== 1'b0)    begin bad++; $display("FAIL rst_dec_en got=%b want=0", dec_en); end
        total++; if (dec_flush !== 1'b1) begin bad++; $display("FAIL rst_dec_flush got=%b want=1", dec_flush); end
        total++; if (pc_load !== 1'b0)   begin bad++; $display("FAIL rst_pc_load got=%b want=0", pc_load); end
        total++; if (mem_err !== 1'b0)   begin bad++; $display("FAIL rst_mem_err got=%b want=0", mem_err); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", stall_cycles); end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            #2;
            total++; if ({fetch_en, dec_en, dec_flush, pc_load} !== 4'b1100)
                begin bad++; $display("FAIL idle_outs cyc=%0d got=%b want=1100", i, {fetch_en, dec_en, dec_flush, pc_load}); end
            tick();
        end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL idle_stall got=%0d want=0", stall_cycles); end
    endtask

    task automatic test_jump(input logic with_lam);
        jmp_taken = 1'b1;
        lam_new   = with_lam;
        #2;
        total++; if ({fetch_en, dec_en, dec_flush, pc_load} !== 4'b1111)
            begin bad++; $display("FAIL jmp_c0 lam=%b got=%b want=1111", with_lam, {fetch_en, dec_en, dec_flush, pc_load}); end
        tick();
        jmp_taken = 1'b0;
        lam_new   = 1'b0;
        #2;
        total++; if ({fetch_en, dec_en, dec_flush, pc_load} !== 4'b1110)
            begin bad++; $display("FAIL jmp_c1 lam=%b got=%b want=1110", with_lam, {fetch_en, dec_en, dec_flush, pc_load}); end
        tick();
        #2;
        total++; if ({fetch_en, dec_en, dec_flush, pc_load} !== 4'b1100)
            begin bad++; $display("FAIL jmp_c2 lam=%b got=%b want=1100", with_lam, {fetch_en, dec_en, dec_flush, pc_load}); end
        tick();
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL jmp_stall lam=%b got=%0d want=0", with_lam, stall_cycles); end
    endtask

    task automatic test_jump_in_flush();
        jmp_taken = 1'b1;
        tick();
        #2;
        total++; if ({dec_flush, pc_load} !== 2'b11) begin bad++; $display("FAIL reflush_c1 got=%b want=11", {dec_flush, pc_load}); end
        tick();
        jmp_taken = 1'b0;
        #2;
        total++; if ({dec_flush, pc_load} !== 2'b10) begin bad++; $display("FAIL reflush_c2 got=%b want=10", {dec_flush, pc_load}); end
        tick();
        #2;
        total++; if ({dec_flush, pc_load} !== 2'b00) begin bad++; $display("FAIL reflush_c3 got=%b want=00", {dec_flush, pc_load}); end
        tick();
    endtask

    task automatic test_mem_stall();
        lam_new   = 1'b1;
        mem_ready = 1'b0;
        #2;
        total++; if ({fetch_en, dec_en} !== 2'b00) begin bad++; $display("FAIL mem_lam got=%b want=00", {fetch_en, dec_en}); end
        tick();
        lam_new = 1'b0;
        for (int i = 1; i < 3; i++) begin
            #2;
            total++; if ({fetch_en, dec_en, dec_flush} !== 3'b000)
                begin bad++; $display("FAIL mem_wait cyc=%0d got=%b want=000", i, {fetch_en, dec_en, dec_flush}); end
            tick();
        end
        mem_ready = 1'b1;
        #2;
        total++; if ({fetch_en, dec_en, dec_flush} !== 3'b110) begin bad++; $display("FAIL mem_ready got=%b want=110", {fetch_en, dec_en, dec_flush}); end
        tick();
        mem_ready = 1'b0;
        #2;
        total++; if (fetch_en !== 1'b1) begin bad++; $display("FAIL mem_after got=%b want=1", fetch_en); end
        total++; if (stall_cycles !== 16'd3) begin bad++; $display("FAIL mem_stall got=%0d want=3", stall_cycles); end
        lam_new   = 1'b1;
        mem_ready = 1'b1;
        #2;
        total++; if ({fetch_en, dec_en, dec_flush} !== 3'b110) begin bad++; $display("FAIL mem_single got=%b want=110", {fetch_en, dec_en, dec_flush}); end
        tick();
        lam_new   = 1'b0;
        mem_ready = 1'b0;
        #2;
        total++; if (fetch_en !== 1'b1) begin bad++; $display("FAIL mem_single_next got=%b want=1", fetch_en); end
        total++; if (stall_cycles !== 16'd3) begin bad++; $display("FAIL mem_single_stall got=%0d want=3", stall_cycles); end
    endtask

    task automatic test_hazard();
        dec_valid  = 1'b1;
        ex_is_load = 1'b1;
        sel_out_ex = 6'd5;
        sel_a_dec  = 6'd5;
        sel_b_dec  = 5'd0;
        uses_b_dec = 1'b0;
        #2;
        total++; if ({fetch_en, dec_en, dec_flush} !== 3'b011) begin bad++; $display("FAIL haz_a got=%b want=011", {fetch_en, dec_en, dec_flush}); end
        tick();
        ex_is_load = 1'b0;
        #2;
        total++; if ({fetch_en, dec_flush} !== 2'b10) begin bad++; $display("FAIL haz_a_next got=%b want=10", {fetch_en, dec_flush}); end
        total++; if (stall_cycles !== 16'd4) begin bad++; $display("FAIL haz_a_stall got=%0d want=4", stall_cycles); end
        ex_is_load = 1'b1;
        sel_a_dec  = 6'd1;
        sel_b_dec  = 5'd5;
        #2;
        total++; if ({fetch_en, dec_flush} !== 2'b10) begin bad++; $display("FAIL haz_b_unused got=%b want=10", {fetch_en, dec_flush}); end
        uses_b_dec = 1'b1;
        #2;
        total++; if ({fetch_en, dec_flush} !== 2'b01) begin bad++; $display("FAIL haz_b_used got=%b want=01", {fetch_en, dec_flush}); end
        tick();
        sel_out_ex = 6'd37;
        #2;
        total++; if (fetch_en !== 1'b1) begin bad++; $display("FAIL haz_b_hi got=%b want=1", fetch_en); end
        sel_out_ex = 6'd0;
        sel_a_dec  = 6'd0;
        sel_b_dec  = 5'd0;
        #2;
        total++; if ({fetch_en, dec_flush} !== 2'b10) begin bad++; $display("FAIL haz_r0 got=%b want=10", {fetch_en, dec_flush}); end
        sel_out_ex = 6'd5;
        sel_a_dec  = 6'd5;
        dec_valid  = 1'b0;
        #2;
        total++; if (fetch_en !== 1'b1) begin bad++; $display("FAIL haz_invalid got=%b want=1", fetch_en); end
        jmp_taken = 1'b1;
        dec_valid = 1'b1;
        #2;
        total++; if ({fetch_en, pc_load} !== 2'b11) begin bad++; $display("FAIL haz_vs_jmp got=%b want=11", {fetch_en, pc_load}); end
        jmp_taken  = 1'b0;
        dec_valid  = 1'b0;
        ex_is_load = 1'b0;
        uses_b_dec = 1'b0;
        tick();
        total++; if (stall_cycles !== 16'd5) begin bad++; $display("FAIL haz_stall got=%0d want=5", stall_cycles); end
    endtask

    task automatic test_timeout();
        lam_new   = 1'b1;
        mem_ready = 1'b0;
        tick();
        lam_new = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            #2;
            total++; if ({mem_err, fetch_en, dec_en} !== 3'b000)
                begin bad++; $display("FAIL tmo_wait cyc=%0d got=%b want=000", i, {mem_err, fetch_en, dec_en}); end
            tick();
        end
        total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b want=1", mem_err); end
        mem_ready = 1'b1;
        jmp_taken = 1'b1;
        #2;
        total++; if ({fetch_en, dec_en, dec_flush, pc_load} !== 4'b0000)
            begin bad++; $display("FAIL err_outs got=%b want=0000", {fetch_en, dec_en, dec_flush, pc_load}); end
        tick();
        jmp_taken = 1'b0;
        #2;
        total++; if ({mem_err, fetch_en} !== 2'b10) begin bad++; $display("FAIL err_sticky got=%b want=10", {mem_err, fetch_en}); end
        total++; if (stall_cycles !== 16'd10) begin bad++; $display("FAIL err_stall got=%0d want=10", stall_cycles); end
        mem_ready = 1'b0;
    endtask

    task automatic test_saturate();
        repeat (70000) @(posedge clk);
        #1;
        total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_stall got=%0h want=ffff", stall_cycles); end
        total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL sat_err got=%b want=1", mem_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        total++; if ({mem_err, stall_cycles} !== 17'd0) begin bad++; $display("FAIL clr got=%b/%0d want=0/0", mem_err, stall_cycles); end
        total++; if ({fetch_en, dec_en, dec_flush} !== 3'b110) begin bad++; $display("FAIL clr_outs got=%b want=110", {fetch_en, dec_en, dec_flush}); end
    endtask

    task automatic test_reset_mid_state();
        lam_new = 1'b1;
        tick();
        lam_new = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            total++; if ({fetch_en, mem_err} !== 2'b10) begin bad++; $display("FAIL rst_memwait cyc=%0d got=%b want=10", i, {fetch_en, mem_err}); end
            tick();
        end
        jmp_taken = 1'b1;
        tick();
        jmp_taken = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        total++; if ({fetch_en, dec_flush, pc_load} !== 3'b100) begin bad++; $display("FAIL rst_flush got=%b want=100", {fetch_en, dec_flush, pc_load}); end
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        dec_valid  = 1'b0;
        sel_a_dec  = 6'd0;
        sel_b_dec  = 5'd0;
        uses_b_dec = 1'b0;
        sel_out_ex = 6'd0;
        ex_is_load = 1'b0;
        jmp_taken  = 1'b0;
        lam_new    = 1'b0;
        mem_ready  = 1'b0;
        #1;
        test_reset();
        test_idle();
        test_jump(1'b0);
        test_jump(1'b1);
        test_jump_in_flush();
        test_mem_stall();
        test_hazard();
        test_timeout();
        test_saturate();
        test_reset_mid_state();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
